autotest_cipher_ctrl: RTL and testbench
=======================================

// Module: autotest_cipher_ctrl
// PURPOSE
//  Parametrised autotest sequencer for block-cipher UUTs. Reads N_VECTORS test vectors from SD card
//  sectors through the sdspihost byte interface, drives key/block/mode into the UUT, measures latency,
//  and writes one result sector per vector back to the card. Sits between sdspihost and the cipher core.
// PARAMETERS
//  BLOCK_W    64          cipher block width, bits; multiple of 8
//  KEY_W      80          key width, bits; multiple of 8; 1+KEY_W/8+BLOCK_W/8 <= 512
//  N_VECTORS  16          vectors per run, 1..65535
//  BASE_ADDR  32'h0       sector of vector 0; result i goes to BASE_ADDR+N_VECTORS+i
//  TIMEOUT    32'hFFFF    max UUT cycles before vector is flagged timed out
// PORTS
//  clk                 in   1        system clock
//  rst                 in   1        synchronous, active-high reset
//  spi_busy            in   1        sdspihost busy
//  spi_err             in   1        sdspihost fatal error
//  spi_data_out        in   8        byte read from card
//  spi_rst             out  1        sdspihost reset
//  spi_block_addr      out  32       sector address
//  spi_r_block/spi_r_byte   out 1    start sector read / fetch next byte (1-cycle pulses)
//  spi_w_block/spi_w_byte   out 1    start sector write / push spi_data_in (1-cycle pulses)
//  spi_data_in         out  8        byte to write
//  rst_uut             out  1        UUT reset, active-high
//  key_uut             out  KEY_W    key to UUT
//  block_i_uut         out  BLOCK_W  input block to UUT
//  encdec_uut          out  1        1 = encrypt, 0 = decrypt
//  block_o_uut         in   BLOCK_W  UUT result
//  end_key_signal_uut  in   1        key schedule finished
//  end_enc_uut/end_dec_uut  in 1     encryption / decryption finished
//  done / error        out  1        run complete / run aborted on spi_err
//  vec_idx             out  16       current vector index
//  sw_debug            in   2        debug mux select
//  debug               out  32       {state,vec_idx}/cycle_cnt/block_o[31:0]/status per sw_debug 0..3
// BEHAVIOUR
//  Reset: spi_rst=1, rst_uut=1, all pulses 0, key/block/encdec/spi_data_in/addr/vec_idx/done/error=0.
//  States: SD_RST -> SD_WAIT -> RD_CMD -> RD_BYTE <-> RD_WAIT -> UUT_RST -> UUT_RUN -> WR_CMD ->
//   WR_BYTE <-> WR_WAIT -> NEXT -> (RD_CMD | DONE); ERROR from any SD state.
//  SD_RST: spi_rst=1 one cycle; SD_WAIT: wait spi_busy=0 (card init done).
//  SD command rule: issue pulse only when spi_busy=0; after any pulse ignore spi_busy for 1 cycle,
//   then wait spi_busy=0 before sampling spi_data_out or issuing next pulse.
//  Read: addr=BASE_ADDR+vec_idx; all 512 bytes consumed. Byte 0 bit0 -> encdec; bytes 1..KEY_W/8 ->
//   key MSB first; next BLOCK_W/8 -> block MSB first; rest discarded. Outputs update only on sampling.
//  UUT_RST: rst_uut=1 exactly 2 cycles, then 0; cycle_cnt cleared, +1 each UUT_RUN cycle (saturates).
//  UUT_RUN exit: end_key_signal_uut seen (sticky) AND end_enc_uut (encdec=1) / end_dec_uut (encdec=0)
//   high -> latch block_o_uut, status=8'h00. cycle_cnt==TIMEOUT first -> status=8'h01, block latched.
//   Done flag and timeout in same cycle: done wins. rst_uut stays 0 until next UUT_RST.
//  Write: addr=BASE_ADDR+N_VECTORS+vec_idx; 512 bytes: status, cycle_cnt[31:0] MSB first,
//   result block MSB first, zero pad.
//  NEXT: vec_idx+1; vec_idx==N_VECTORS-1 -> DONE (done=1, held until rst). Index never wraps.
//  spi_err=1 in any SD state -> ERROR: error=1, pulses 0, rst_uut=1, held until rst.
//  rst mid-operation: immediate return to reset values next cycle; partial sector abandoned.
// TESTING
//  1 vec, SD model sector0={01,key 00..00,block 00..00}, UUT model end after 32 cyc -> sector1 byte0=00,
//   cycle bytes 00000020, block matches model, done=1.
//  encdec=0 vector: end_enc pulses but end_dec at 40 -> count 00000028, end_enc ignored.
//  UUT never ends, TIMEOUT=100 -> status 01, count 00000064, run continues to next vector.
//  N_VECTORS=3: addresses read 0,1,2, written 3,4,5 in order; exactly 512 r_byte and 512 w_byte per sector.
//  spi_err asserted during byte 200 of read -> error=1, rst_uut=1, no further pulses.
//  rst asserted during WR_BYTE -> next cycle reset values; rerun reproduces identical sectors.

Source files
------------

// File: rtl/autotest_cipher_ctrl.sv
// Autotest sequencer for block-cipher UUTs: pulls test vectors from SD sectors
// via the sdspihost byte interface, runs the UUT, times it, and writes one
// result sector per vector back to the card.
module autotest_cipher_ctrl #(
  parameter int          BLOCK_W   = 64,
  parameter int          KEY_W     = 80,
  parameter int          N_VECTORS = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter logic [31:0] TIMEOUT   = 32'hFFFF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               spi_busy,
  input  logic               spi_err,
  input  logic [7:0]         spi_data_out,
  output logic               spi_rst,
  output logic [31:0]        spi_block_addr,
  output logic               spi_r_block,
  output logic               spi_r_byte,
  output logic               spi_w_block,
  output logic               spi_w_byte,
  output logic [7:0]         spi_data_in,
  output logic               rst_uut,
  output logic [KEY_W-1:0]   key_uut,
  output logic [BLOCK_W-1:0] block_i_uut,
  output logic               encdec_uut,
  input  logic [BLOCK_W-1:0] block_o_uut,
  input  logic               end_key_signal_uut,
  input  logic               end_enc_uut,
  input  logic               end_dec_uut,
  output logic               done,
  output logic               error,
  output logic [15:0]        vec_idx,
  input  logic [1:0]         sw_debug,
  output logic [31:0]        debug
);
  localparam int KB   = KEY_W / 8;
  localparam int BB   = BLOCK_W / 8;
  localparam int WR_W = 40 + BLOCK_W;  // status + cycle count + result

  typedef enum logic [3:0] {
    S_SD_RST, S_SD_WAIT, S_RD_CMD, S_RD_BYTE, S_RD_WAIT, S_UUT_RST, S_UUT_RUN,
    S_WR_CMD, S_WR_BYTE, S_WR_WAIT, S_NEXT, S_DONE, S_ERROR
  } state_t;

  state_t             state, state_nx;
  logic               skip;        // busy is not yet meaningful right after a pulse
  logic [8:0]         byte_cnt;
  logic               rst_cnt;
  logic [15:0]        vec_idx_q;
  logic [KEY_W-1:0]   key_q;
  logic [BLOCK_W-1:0] blk_q;
  logic               encdec_q;
  logic [31:0]        cycle_cnt;
  logic               key_seen;
  logic [BLOCK_W-1:0] result_q;
  logic [7:0]         status_q;
  logic               uut_rst_q;

  logic               go, sd_state, uut_fin, time_hit, last_vec, pulse_any;
  logic [31:0]        cnt_inc;
  logic [WR_W-1:0]    wr_sh;

  assign go        = !skip && !spi_busy && !spi_err;
  assign sd_state  = state inside {S_SD_RST, S_SD_WAIT, S_RD_CMD, S_RD_BYTE, S_RD_WAIT,
                                   S_WR_CMD, S_WR_BYTE, S_WR_WAIT};
  assign uut_fin   = (key_seen || end_key_signal_uut) && (encdec_q ? end_enc_uut : end_dec_uut);
  assign cnt_inc   = (cycle_cnt == 32'hFFFF_FFFF) ? cycle_cnt : cycle_cnt + 32'd1;
  assign time_hit  = cnt_inc >= TIMEOUT;
  assign last_vec  = vec_idx_q == 16'(N_VECTORS - 1);
  assign pulse_any = spi_r_block | spi_r_byte | spi_w_block | spi_w_byte;
  // result sector bytes are taken MSB first, zero pad falls out of the shift
  assign wr_sh     = {status_q, cycle_cnt, result_q} << {byte_cnt, 3'b000};

  assign key_uut     = key_q;
  assign block_i_uut = blk_q;
  assign encdec_uut  = encdec_q;
  assign vec_idx     = vec_idx_q;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_SD_RST;
    else     state <= state_nx;
  end

  // next-state logic; a card error in any SD-facing state aborts the run
  always_comb begin
    state_nx = state;
    case (state)
      S_SD_RST:  state_nx = S_SD_WAIT;
      S_SD_WAIT: if (go) state_nx = S_RD_CMD;
      S_RD_CMD:  if (go) state_nx = S_RD_BYTE;
      S_RD_BYTE: if (go) state_nx = S_RD_WAIT;
      S_RD_WAIT: if (go) state_nx = (byte_cnt == 9'd511) ? S_UUT_RST : S_RD_BYTE;
      S_UUT_RST: if (rst_cnt) state_nx = S_UUT_RUN;
      S_UUT_RUN: if (uut_fin || time_hit) state_nx = S_WR_CMD;
      S_WR_CMD:  if (go) state_nx = S_WR_BYTE;
      S_WR_BYTE: if (go) state_nx = S_WR_WAIT;
      S_WR_WAIT: if (go) state_nx = (byte_cnt == 9'd511) ? S_NEXT : S_WR_BYTE;
      S_NEXT:    state_nx = last_vec ? S_DONE : S_RD_CMD;
      default:   state_nx = state;
    endcase
    if (sd_state && spi_err) state_nx = S_ERROR;
  end

  // outputs decoded from state; command pulses only fire when the host is idle
  always_comb begin
    spi_rst     = (state == S_SD_RST);
    spi_r_block = (state == S_RD_CMD)  && go;
    spi_r_byte  = (state == S_RD_BYTE) && go;
    spi_w_block = (state == S_WR_CMD)  && go;
    spi_w_byte  = (state == S_WR_BYTE) && go;
    rst_uut     = uut_rst_q || (state == S_UUT_RST) || (state == S_ERROR);
    done        = (state == S_DONE);
    error       = (state == S_ERROR);
    spi_block_addr = 32'h0;
    if (state inside {S_RD_CMD, S_RD_BYTE, S_RD_WAIT})
      spi_block_addr = BASE_ADDR + 32'(vec_idx_q);
    else if (state inside {S_WR_CMD, S_WR_BYTE, S_WR_WAIT})
      spi_block_addr = BASE_ADDR + 32'(N_VECTORS) + 32'(vec_idx_q);
    spi_data_in = 8'h00;
    if (state inside {S_WR_BYTE, S_WR_WAIT}) spi_data_in = wr_sh[WR_W-1 -: 8];
  end

  // datapath: vector capture, UUT timing and result latching
  always_ff @(posedge clk) begin
    if (rst) begin
      skip      <= 1'b0;
      byte_cnt  <= '0;
      rst_cnt   <= 1'b0;
      vec_idx_q <= '0;
      key_q     <= '0;
      blk_q     <= '0;
      encdec_q  <= 1'b0;
      cycle_cnt <= '0;
      key_seen  <= 1'b0;
      result_q  <= '0;
      status_q  <= '0;
      uut_rst_q <= 1'b1;
    end else begin
      skip <= pulse_any || (state == S_SD_RST);
      case (state)
        S_RD_CMD, S_WR_CMD: if (go) byte_cnt <= '0;
        S_RD_WAIT: if (go) begin
          byte_cnt <= byte_cnt + 9'd1;
          if (byte_cnt == 9'd0)                 encdec_q <= spi_data_out[0];
          else if (int'(byte_cnt) <= KB)        key_q    <= (key_q << 8) | KEY_W'(spi_data_out);
          else if (int'(byte_cnt) <= KB + BB)   blk_q    <= (blk_q << 8) | BLOCK_W'(spi_data_out);
        end
        S_UUT_RST: begin
          rst_cnt   <= ~rst_cnt;
          cycle_cnt <= '0;
          key_seen  <= 1'b0;
          uut_rst_q <= 1'b0;
        end
        S_UUT_RUN: begin
          cycle_cnt <= cnt_inc;
          if (end_key_signal_uut) key_seen <= 1'b1;
          if (uut_fin) begin
            result_q <= block_o_uut;
            status_q <= 8'h00;
          end else if (time_hit) begin
            result_q <= block_o_uut;
            status_q <= 8'h01;
          end
        end
        S_WR_WAIT: if (go) byte_cnt <= byte_cnt + 9'd1;
        S_NEXT: if (!last_vec) vec_idx_q <= vec_idx_q + 16'd1;
        default: ;
      endcase
    end
  end

  // debug view selector
  always_comb begin
    case (sw_debug)
      2'd0:    debug = {12'h0, state, vec_idx_q};
      2'd1:    debug = cycle_cnt;
      2'd2:    debug = 32'(result_q);
      default: debug = {22'h0, error, done, status_q};
    endcase
  end
endmodule

// File: tb/tb_autotest_cipher_ctrl.sv
// Bench for autotest_cipher_ctrl: behavioural SD card and cipher UUT models,
// random vector contents, expected result sectors computed from the vector data.
module tb_autotest_cipher_ctrl;
  localparam int          BW = 64;
  localparam int          KW = 80;
  localparam int          NV = 3;
  localparam int          KB = KW / 8;
  localparam int          BB = BW / 8;
  localparam logic [31:0] TO = 32'd100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          spi_busy = 1'b0, spi_err = 1'b0;
  logic [7:0]    spi_data_out = 8'h00;
  logic          spi_rst, spi_r_block, spi_r_byte, spi_w_block, spi_w_byte;
  logic [31:0]   spi_block_addr;
  logic [7:0]    spi_data_in;
  logic          rst_uut, encdec_uut;
  logic [KW-1:0] key_uut;
  logic [BW-1:0] block_i_uut, block_o_uut;
  logic          end_key_signal_uut, end_enc_uut, end_dec_uut;
  logic          done, error;
  logic [15:0]   vec_idx;
  logic [1:0]    sw_debug = 2'd0;
  logic [31:0]   debug;

  autotest_cipher_ctrl #(.BLOCK_W(BW), .KEY_W(KW), .N_VECTORS(NV),
                         .BASE_ADDR(32'h0), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .spi_busy(spi_busy), .spi_err(spi_err),
    .spi_data_out(spi_data_out), .spi_rst(spi_rst), .spi_block_addr(spi_block_addr),
    .spi_r_block(spi_r_block), .spi_r_byte(spi_r_byte), .spi_w_block(spi_w_block),
    .spi_w_byte(spi_w_byte), .spi_data_in(spi_data_in), .rst_uut(rst_uut),
    .key_uut(key_uut), .block_i_uut(block_i_uut), .encdec_uut(encdec_uut),
    .block_o_uut(block_o_uut), .end_key_signal_uut(end_key_signal_uut),
    .end_enc_uut(end_enc_uut), .end_dec_uut(end_dec_uut), .done(done), .error(error),
    .vec_idx(vec_idx), .sw_debug(sw_debug), .debug(debug));

  int errors = 0;
  int checks = 0;

  // test vectors and expected UUT latency per vector
  logic [KW-1:0] vkey  [0:NV-1];
  logic [BW-1:0] vblk  [0:NV-1];
  logic          vmode [0:NV-1];
  int            exp_cnt [0:NV-1] = '{32, 40, 100};

  // ---------------- SD card model ----------------
  logic [7:0] rd_mem [0:NV-1][0:511];
  logic [7:0] wr_mem [0:2*NV-1][0:511];
  int rbyte_cnt [0:2*NV-1];
  int wbyte_cnt [0:2*NV-1];
  int rd_order[$];
  int wr_order[$];
  int busy_cnt = 0, cur_addr = 0, ptr = 0, proto_err = 0, pulse_cnt = 0, np;
  logic clr_req = 1'b0, err_arm = 1'b0, err_hit = 1'b0;

  always @(posedge clk) begin
    if (clr_req) begin
      for (int a = 0; a < 2*NV; a++) begin
        rbyte_cnt[a] = 0;
        wbyte_cnt[a] = 0;
        for (int b = 0; b < 512; b++) wr_mem[a][b] = 8'hA5;
      end
      rd_order.delete();
      wr_order.delete();
      proto_err = 0;
      pulse_cnt = 0;
    end
    np = int'(spi_r_block) + int'(spi_r_byte) + int'(spi_w_block) + int'(spi_w_byte);
    pulse_cnt += np;
    if (np > 0 && spi_busy) proto_err++;
    if (np > 1) proto_err++;
    if (busy_cnt > 0) busy_cnt--;
    if (spi_rst) begin busy_cnt = 8; ptr = 0; end
    if (spi_r_block || spi_w_block) begin
      cur_addr = int'(spi_block_addr);
      ptr = 0;
      busy_cnt = $urandom_range(0, 3);
      if (spi_r_block) rd_order.push_back(cur_addr);
      else             wr_order.push_back(cur_addr);
    end
    if (spi_r_byte) begin
      spi_data_out <= (cur_addr >= 0 && cur_addr < NV && ptr < 512) ? rd_mem[cur_addr][ptr] : 8'h00;
      if (cur_addr >= 0 && cur_addr < 2*NV) rbyte_cnt[cur_addr]++;
      ptr++;
      busy_cnt = $urandom_range(0, 2);
      if (err_arm && ptr == 200) err_hit = 1'b1;
    end
    if (spi_w_byte) begin
      if (cur_addr >= 0 && cur_addr < 2*NV) begin
        if (ptr < 512) wr_mem[cur_addr][ptr] = spi_data_in;
        wbyte_cnt[cur_addr]++;
      end
      ptr++;
      busy_cnt = $urandom_range(0, 2);
    end
    if (!err_arm) err_hit = 1'b0;
    spi_err  <= err_hit;
    spi_busy <= (busy_cnt > 0);
  end

  // ---------------- cipher UUT model ----------------
  // run_cnt counts cycles since release of rst_uut; vector 0 encrypts in 32,
  // vector 1 decrypts in 40 with stray end_enc pulses, vector 2 never finishes.
  int run_cnt = 0;
  always @(posedge clk) begin
    if (rst_uut) run_cnt <= 0;
    else         run_cnt <= run_cnt + 1;
  end

  always_comb begin
    end_key_signal_uut = 1'b0;
    end_enc_uut        = 1'b0;
    end_dec_uut        = 1'b0;
    block_o_uut        = 64'h0;
    if (!rst_uut) begin
      block_o_uut = block_i_uut ^ key_uut[63:0] ^ (encdec_uut ? 64'h0 : {64{1'b1}});
      case (vec_idx)
        16'd0: begin
          end_key_signal_uut = (run_cnt == 4);
          end_enc_uut        = (run_cnt >= 31);
          end_dec_uut        = (run_cnt % 3 == 0);
        end
        16'd1: begin
          end_key_signal_uut = (run_cnt == 9);
          end_enc_uut        = (run_cnt % 5 == 2);
          end_dec_uut        = (run_cnt >= 39);
        end
        default: end_key_signal_uut = (run_cnt >= 2);
      endcase
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string p);
    chk({p, "_spi_rst"}, 128'(spi_rst), 128'(1'b1));
    chk({p, "_rst_uut"}, 128'(rst_uut), 128'(1'b1));
    chk({p, "_pulses"}, 128'({spi_r_block, spi_r_byte, spi_w_block, spi_w_byte}), 128'(4'b0));
    chk({p, "_key"}, 128'(key_uut), 128'(0));
    chk({p, "_block"}, 128'(block_i_uut), 128'(0));
    chk({p, "_encdec"}, 128'(encdec_uut), 128'(1'b0));
    chk({p, "_data_in"}, 128'(spi_data_in), 128'(8'h0));
    chk({p, "_addr"}, 128'(spi_block_addr), 128'(32'h0));
    chk({p, "_vec_idx"}, 128'(vec_idx), 128'(16'h0));
    chk({p, "_done"}, 128'(done), 128'(1'b0));
    chk({p, "_error"}, 128'(error), 128'(1'b0));
  endtask

  task automatic wait_end(input int budget);
    int n = 0;
    while (!(done || error) && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic check_run(input string p);
    chk({p, "_done"}, 128'(done), 128'(1'b1));
    chk({p, "_error"}, 128'(error), 128'(1'b0));
    chk({p, "_vec_idx_final"}, 128'(vec_idx), 128'(NV - 1));
    chk({p, "_rst_uut_low"}, 128'(rst_uut), 128'(1'b0));
    chk({p, "_protocol"}, 128'(proto_err), 128'(0));
    chk({p, "_rd_sectors"}, 128'(rd_order.size()), 128'(NV));
    chk({p, "_wr_sectors"}, 128'(wr_order.size()), 128'(NV));
    for (int v = 0; v < NV; v++) begin
      chk($sformatf("%s_rd_addr%0d", p, v), 128'((v < rd_order.size()) ? rd_order[v] : -1), 128'(v));
      chk($sformatf("%s_wr_addr%0d", p, v), 128'((v < wr_order.size()) ? wr_order[v] : -1), 128'(NV + v));
      chk($sformatf("%s_rd_bytes%0d", p, v), 128'(rbyte_cnt[v]), 128'(512));
      chk($sformatf("%s_wr_bytes%0d", p, v), 128'(wbyte_cnt[NV + v]), 128'(512));
      check_sector(v, p);
    end
  endtask

  task automatic check_sector(input int v, input string p);
    logic [31:0] cnt;
    logic [63:0] blk;
    logic [63:0] eblk;
    int nz = 0;
    int a = NV + v;
    cnt = {wr_mem[a][1], wr_mem[a][2], wr_mem[a][3], wr_mem[a][4]};
    blk = 64'h0;
    for (int i = 0; i < BB; i++) blk = {blk[55:0], wr_mem[a][5 + i]};
    for (int i = 5 + BB; i < 512; i++) if (wr_mem[a][i] != 8'h00) nz++;
    eblk = vblk[v] ^ vkey[v][63:0] ^ (vmode[v] ? 64'h0 : {64{1'b1}});
    chk($sformatf("%s_status%0d", p, v), 128'(wr_mem[a][0]), 128'((v == 2) ? 8'h01 : 8'h00));
    chk($sformatf("%s_cycles%0d", p, v), 128'(cnt), 128'(exp_cnt[v]));
    chk($sformatf("%s_result%0d", p, v), 128'(blk), 128'(eblk));
    chk($sformatf("%s_pad%0d", p, v), 128'(nz), 128'(0));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int p0;
    int n;
    for (int v = 0; v < NV; v++) begin
      vkey[v]  = {16'($urandom), $urandom, $urandom};
      vblk[v]  = {$urandom, $urandom};
      vmode[v] = (v == 0) ? 1'b1 : (v == 1) ? 1'b0 : 1'($urandom);
      rd_mem[v][0] = {7'($urandom), vmode[v]};
      for (int i = 1; i <= KB; i++) rd_mem[v][i] = vkey[v][KW - 8*i +: 8];
      for (int i = 0; i < BB; i++) rd_mem[v][1 + KB + i] = vblk[v][BW - 8*(i + 1) +: 8];
      for (int i = 1 + KB + BB; i < 512; i++) rd_mem[v][i] = 8'($urandom);
    end

    // reset state
    clr_req = 1'b1;
    repeat (3) @(negedge clk);
    clr_req = 1'b0;
    check_reset("reset");

    // full run: encrypt, decrypt with stray end_enc, timeout
    rst = 1'b0;
    wait_end(40000);
    check_run("run1");
    chk("run1_key_final", 128'(key_uut), 128'(vkey[NV-1]));
    chk("run1_block_final", 128'(block_i_uut), 128'(vblk[NV-1]));
    chk("run1_encdec_final", 128'(encdec_uut), 128'(vmode[NV-1]));
    sw_debug = 2'd1;
    #1 chk("debug_cycles", 128'(debug), 128'(TO));
    sw_debug = 2'd0;
    #1 chk("debug_vec_idx", 128'(debug[15:0]), 128'(NV - 1));
    p0 = pulse_cnt;
    repeat (20) @(negedge clk);
    chk("done_no_pulses", 128'(pulse_cnt), 128'(p0));
    chk("done_held", 128'(done), 128'(1'b1));

    // reset in the middle of writing sector of vector 1, then rerun
    rst = 1'b1;
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    rst = 1'b0;
    n = 0;
    while (!(wr_order.size() >= 2 && wbyte_cnt[NV + 1] > 100) && n < 30000) begin
      @(negedge clk);
      n++;
    end
    chk("midwrite_reached", 128'(wbyte_cnt[NV + 1] > 100), 128'(1'b1));
    rst = 1'b1;
    @(negedge clk);
    check_reset("midwrite_rst");
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    rst = 1'b0;
    wait_end(40000);
    check_run("rerun");

    // card error during byte 200 of the first read
    rst = 1'b1;
    clr_req = 1'b1;
    err_arm = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    rst = 1'b0;
    wait_end(10000);
    chk("err_error", 128'(error), 128'(1'b1));
    chk("err_done", 128'(done), 128'(1'b0));
    chk("err_rst_uut", 128'(rst_uut), 128'(1'b1));
    chk("err_rd_bytes", 128'(rbyte_cnt[0]), 128'(200));
    p0 = pulse_cnt;
    repeat (50) @(negedge clk);
    chk("err_no_pulses", 128'(pulse_cnt), 128'(p0));
    err_arm = 1'b0;
    repeat (5) @(negedge clk);
    chk("err_held", 128'(error), 128'(1'b1));
    chk("err_rst_uut_held", 128'(rst_uut), 128'(1'b1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
